// File: rtl/float_div_recip_stage.sv
// Divider wrapper: quotient = dividend * recip_y, aligned to an external fixed-latency reciprocal
// pipeline and credit-throttled into a show-ahead output FIFO. Optional special cases: FLOAT_DIV_SPECIAL_EN.
module float_div_recip_stage #(
  parameter int unsigned MANTISSA_SIZE = 23,
  parameter int unsigned RECIP_LATENCY = 24,
  parameter int unsigned FIFO_DEPTH    = 32,
  localparam int unsigned FLOAT_SIZE   = 9 + MANTISSA_SIZE
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [FLOAT_SIZE-1:0] s_dividend,
  input  logic [FLOAT_SIZE-1:0] s_divisor,
  output logic [FLOAT_SIZE-1:0] recip_x,
  input  logic [FLOAT_SIZE-1:0] recip_y,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FLOAT_SIZE-1:0] m_quotient
);

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = MANTISSA_SIZE;
  localparam int unsigned SIG_W  = MANT_W + 1;
  localparam int unsigned PROD_W = 2 * SIG_W;
  localparam int unsigned KEEP_W = SIG_W + 1;
  localparam int unsigned SEXP_W = EXP_W + 2;
  localparam int unsigned BIAS   = 127;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
`ifdef FLOAT_DIV_SPECIAL_EN
  localparam int unsigned FLAG_W  = 3;
  localparam int unsigned EXP_MAX = 255;
`else
  localparam int unsigned FLAG_W  = 0;
`endif
  localparam int unsigned DLY_W = FLOAT_SIZE + FLAG_W;

  logic                                 fire_in;
  logic                                 pop;
  logic [CNT_W-1:0]                     credits_q, credits_d;
  logic                                 s_ready_q, s_ready_d;
  logic [RECIP_LATENCY-1:0]             tok_q, tok_d;
  logic [RECIP_LATENCY-1:0][DLY_W-1:0]  dly_q, dly_d;
  logic [DLY_W-1:0]                     dly_in;
  logic [FLOAT_SIZE-1:0]                a_word;

  logic                                 s1_vld_q, s1_vld_d;
  logic                                 s1_sign_q, s1_sign_d;
  logic signed [SEXP_W-1:0]             s1_exp_q, s1_exp_d;
  logic [KEEP_W-1:0]                    s1_prod_q, s1_prod_d;
`ifdef FLOAT_DIV_SPECIAL_EN
  logic                                 s1_inf_q, s1_inf_d;
  logic                                 s1_zero_q, s1_zero_d;
  logic                                 s1_nan_q, s1_nan_d;
  logic                                 s1_ssign_q, s1_ssign_d;
`endif

  logic signed [SEXP_W-1:0]             norm_exp;
  logic [MANT_W-1:0]                    norm_mant;
  logic                                 s2_vld_q, s2_vld_d;
  logic [FLOAT_SIZE-1:0]                s2_res_q, s2_res_d;

  logic [FLOAT_SIZE-1:0]                mem_q [FIFO_DEPTH];
  logic                                 mem_we;
  logic                                 mem_empty;
  logic                                 mem_full;
  logic                                 out_free;
  logic [PTR_W:0]                       wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]                       rd_ptr_q, rd_ptr_d;
  logic                                 m_valid_q, m_valid_d;
  logic [FLOAT_SIZE-1:0]                m_quot_q, m_quot_d;

  assign recip_x    = s_divisor;
  assign s_ready    = s_ready_q;
  assign m_valid    = m_valid_q;
  assign m_quotient = m_quot_q;

  // Accept, credit accounting and latency-matching delay lines.
  always_comb begin
    fire_in   = s_valid & s_ready_q;
    pop       = m_valid_q & m_ready;
    credits_d = credits_q + CNT_W'(fire_in) - CNT_W'(pop);
    s_ready_d = (credits_d < CNT_W'(FIFO_DEPTH));
`ifdef FLOAT_DIV_SPECIAL_EN
    dly_in = {s_divisor[FLOAT_SIZE-1],
              (s_divisor[FLOAT_SIZE-2 -: EXP_W] == '0),
              (s_divisor[FLOAT_SIZE-2 -: EXP_W] == {EXP_W{1'b1}}),
              s_dividend};
`else
    dly_in = s_dividend;
`endif
    tok_d = {tok_q[RECIP_LATENCY-2:0], fire_in};
    dly_d = {dly_q[RECIP_LATENCY-2:0], dly_in};
  end

  // Stage 1: sign, biased exponent sum and the upper mantissa product bits kept by truncation.
  always_comb begin
    a_word    = dly_q[RECIP_LATENCY-1][FLOAT_SIZE-1:0];
    s1_vld_d  = tok_q[RECIP_LATENCY-1];
    s1_sign_d = a_word[FLOAT_SIZE-1] ^ recip_y[FLOAT_SIZE-1];
    s1_exp_d  = $signed(SEXP_W'(a_word[FLOAT_SIZE-2 -: EXP_W]))
              + $signed(SEXP_W'(recip_y[FLOAT_SIZE-2 -: EXP_W]))
              - $signed(SEXP_W'(BIAS));
    s1_prod_d = KEEP_W'((PROD_W'({1'b1, a_word[MANT_W-1:0]})
                       * PROD_W'({1'b1, recip_y[MANT_W-1:0]})) >> MANT_W);
`ifdef FLOAT_DIV_SPECIAL_EN
    s1_ssign_d = a_word[FLOAT_SIZE-1] ^ dly_q[RECIP_LATENCY-1][DLY_W-1];
    s1_inf_d   = dly_q[RECIP_LATENCY-1][DLY_W-2];
    s1_zero_d  = (a_word[FLOAT_SIZE-2 -: EXP_W] == '0);
    s1_nan_d   = (a_word[FLOAT_SIZE-2 -: EXP_W] == {EXP_W{1'b1}}) | dly_q[RECIP_LATENCY-1][DLY_W-3];
`endif
  end

  // Stage 2: normalise by one bit at most, flush underflow to signed zero.
  always_comb begin
    s2_vld_d = s1_vld_q;
    if (s1_prod_q[KEEP_W-1]) begin
      norm_mant = s1_prod_q[KEEP_W-2 -: MANT_W];
      norm_exp  = s1_exp_q + SEXP_W'(1);
    end else begin
      norm_mant = s1_prod_q[MANT_W-1:0];
      norm_exp  = s1_exp_q;
    end
    s2_res_d = {s1_sign_q, norm_exp[EXP_W-1:0], norm_mant};
    if (norm_exp[SEXP_W-1] || (norm_exp == '0)) begin
      s2_res_d = {s1_sign_q, (FLOAT_SIZE-1)'(0)};
    end
`ifdef FLOAT_DIV_SPECIAL_EN
    // Later assignments take priority: b==0, then a==0, then NaN, then overflow.
    if (!norm_exp[SEXP_W-1] && (norm_exp >= $signed(SEXP_W'(EXP_MAX)))) begin
      s2_res_d = {s1_sign_q, {EXP_W{1'b1}}, MANT_W'(0)};
    end
    if (s1_nan_q) begin
      s2_res_d = {1'b0, {EXP_W{1'b1}}, 1'b1, (MANT_W-1)'(0)};
    end
    if (s1_zero_q) begin
      s2_res_d = {s1_ssign_q, (FLOAT_SIZE-1)'(0)};
    end
    if (s1_inf_q) begin
      s2_res_d = {s1_ssign_q, {EXP_W{1'b1}}, MANT_W'(0)};
    end
`endif
  end

  // Show-ahead FIFO: output register backed by memory; writes bypass memory when it is empty.
  always_comb begin
    mem_empty = (wr_ptr_q == rd_ptr_q);
    mem_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    out_free  = !m_valid_q | m_ready;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    m_valid_d = m_valid_q;
    m_quot_d  = m_quot_q;
    mem_we    = 1'b0;
    if (out_free) begin
      if (!mem_empty) begin
        m_valid_d = 1'b1;
        m_quot_d  = mem_q[rd_ptr_q[PTR_W-1:0]];
        rd_ptr_d  = rd_ptr_q + (PTR_W+1)'(1);
        mem_we    = s2_vld_q;
      end else if (s2_vld_q) begin
        m_valid_d = 1'b1;
        m_quot_d  = s2_res_q;
      end else begin
        m_valid_d = 1'b0;
      end
    end else begin
      mem_we = s2_vld_q;
    end
    if (mem_full && (rd_ptr_d == rd_ptr_q)) begin
      mem_we = 1'b0;
    end
    if (mem_we) begin
      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    end
  end

  // Control state: tokens, credits, pointers and output register are reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      credits_q  <= '0;
      s_ready_q  <= 1'b0;
      tok_q      <= '0;
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      m_valid_q  <= 1'b0;
      m_quot_q   <= '0;
    end else begin
      credits_q  <= credits_d;
      s_ready_q  <= s_ready_d;
      tok_q      <= tok_d;
      s1_vld_q   <= s1_vld_d;
      s2_vld_q   <= s2_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      m_valid_q  <= m_valid_d;
      m_quot_q   <= m_quot_d;
    end
  end

  // Datapath registers carry no reset; they are qualified by the token bits.
  always_ff @(posedge clk) begin
    dly_q      <= dly_d;
    s1_sign_q  <= s1_sign_d;
    s1_exp_q   <= s1_exp_d;
    s1_prod_q  <= s1_prod_d;
    s2_res_q   <= s2_res_d;
`ifdef FLOAT_DIV_SPECIAL_EN
    s1_inf_q   <= s1_inf_d;
    s1_zero_q  <= s1_zero_d;
    s1_nan_q   <= s1_nan_d;
    s1_ssign_q <= s1_ssign_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= s2_res_q;
    end
  end

endmodule

// File: tb/tb_float_div_recip_stage.sv
// Directed bench for float_div_recip_stage with a fixed-latency reciprocal model in the loop.
module tb_float_div_recip_stage;

  localparam int unsigned LAT   = 24;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned FS    = 32;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          s_valid = 1'b0;
  logic          m_ready = 1'b0;
  logic          s_ready;
  logic          m_valid;
  logic [FS-1:0] s_dividend = '0;
  logic [FS-1:0] s_divisor = '0;
  logic [FS-1:0] recip_x;
  logic [FS-1:0] recip_y;
  logic [FS-1:0] m_quotient;

  logic [LAT-1:0][FS-1:0] rpipe;
  logic [FS-1:0] exp_q[$];
  logic [FS-1:0] got_q[$];
  int            pop_cyc_q[$];
  int            cyc = 0;
  int            n_vec = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  float_div_recip_stage dut (
    .clk        (clk),
    .resetn     (resetn),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_dividend (s_dividend),
    .s_divisor  (s_divisor),
    .recip_x    (recip_x),
    .recip_y    (recip_y),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_quotient (m_quotient)
  );

  // Reciprocal unit model: exact for powers of two, table entries for a couple of other divisors.
  function automatic logic [FS-1:0] recip_model(input logic [FS-1:0] b);
    logic [7:0] e;
    e = b[30:23];
    if (b[30:0] == 31'h40400000) return {b[31], 31'h3EAAAAAA};
    if (b[30:0] == 31'h3F2AAAAB) return {b[31], 31'h3FC00000};
    if (e == 8'd0) return {b[31], 8'hFF, 23'h0};
    if ((b[22:0] == 23'h0) && (e <= 8'd253)) return {b[31], 8'(8'd254 - e), 23'h0};
    return {b[31], 31'h0};
  endfunction

  always @(posedge clk) rpipe <= {rpipe[LAT-2:0], recip_model(recip_x)};
  assign recip_y = rpipe[LAT-1];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (m_valid && m_ready) begin
      got_q.push_back(m_quotient);
      pop_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [FS-1:0] obs, input logic [FS-1:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Present one pair, wait for acceptance (bounded), leave the bench in the following cycle.
  task automatic push_pair(input logic [FS-1:0] a, input logic [FS-1:0] b, output int stalls);
    s_valid    = 1'b1;
    s_dividend = a;
    s_divisor  = b;
    stalls     = 0;
    while (!s_ready && stalls < 200) begin
      tick;
      stalls++;
    end
    if (!s_ready) check("accept_timeout", 32'(s_ready), 32'd1);
    tick;
    s_valid = 1'b0;
  endtask

  // Single division on an idle pipeline: checks latency from accept and the quotient.
  task automatic run_one(input string tag, input logic [FS-1:0] a, input logic [FS-1:0] b,
                         input logic [FS-1:0] q);
    int k;
    int st;
    m_ready = 1'b1;
    push_pair(a, b, st);
    k = 1;
    while (!m_valid && k < 60) begin
      tick;
      k++;
    end
    check({tag, "_latency"}, 32'(k), 32'd27);
    check({tag, "_quotient"}, m_quotient, q);
    tick;
  endtask

  function automatic logic [FS-1:0] bp_a(input int i);
    return {1'b0, 8'd130, 23'(i * 9973)};
  endfunction

  function automatic logic [FS-1:0] bp_q(input int i);
    return {1'b0, 8'd129, 23'(i * 9973)};
  endfunction

  initial begin
    logic [31:0]   r;
    logic [FS-1:0] a;
    logic [FS-1:0] b;
    logic [7:0]    ea;
    logic [7:0]    eb;
    int            st;
    int            stalls;
    int            base;
    int            accepts;
    int            seen;
    int            c;

    // Reset state.
    #2 resetn = 1'b0;
    #1;
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_quotient", m_quotient, 32'h0);
    tick; tick; tick;
    check("rst_hold_s_ready", 32'(s_ready), 32'd0);
    resetn = 1'b1;
    tick;
    check("post_rst_s_ready", 32'(s_ready), 32'd1);

    // Single operations, sign handling, normalisation carry and the underflow boundary.
    run_one("div_6_2", 32'h40C00000, 32'h40000000, 32'h40400000);
    tick; tick;
    check("empty_m_valid", 32'(m_valid), 32'd0);
    check("empty_hold_quotient", m_quotient, 32'h40400000);
    run_one("div_n6_2", 32'hC0C00000, 32'h40000000, 32'hC0400000);
    run_one("div_n6_n2", 32'hC0C00000, 32'hC0000000, 32'h40400000);
    run_one("div_6_3", 32'h40C00000, 32'h40400000, 32'h3FFFFFFF);
    run_one("div_carry", 32'h3FC00000, 32'h3F2AAAAB, 32'h40100000);
    run_one("underflow_pos", 32'h00800000, 32'h40800000, 32'h00000000);
    run_one("underflow_neg", 32'h80800000, 32'h40800000, 32'h80000000);
    run_one("min_normal", 32'h01000000, 32'h40000000, 32'h00800000);

    // Streaming: 200 back-to-back pairs with m_ready held high.
    m_ready = 1'b1;
    base = got_q.size();
    exp_q.delete();
    stalls = 0;
    r = 32'h1234_5678;
    for (int i = 0; i < 200; i++) begin
      r  = r * 32'd1664525 + 32'd1013904223;
      ea = 8'(8'd64 + {1'b0, r[30:24]});
      eb = 8'(8'd120 + {4'b0, r[11:8]});
      a  = {r[31], ea, r[22:0]};
      b  = {r[12], eb, 23'h0};
      exp_q.push_back({r[31] ^ r[12], 8'(ea - eb + 8'd127), r[22:0]});
      push_pair(a, b, st);
      stalls += st;
    end
    check("stream_stalls", 32'(stalls), 32'd0);
    c = 0;
    while (got_q.size() < base + 200 && c < 100) begin
      tick;
      c++;
    end
    check("stream_count", 32'(got_q.size() - base), 32'd200);
    if (got_q.size() >= base + 200) begin
      check("stream_one_per_cycle", 32'(pop_cyc_q[base + 199] - pop_cyc_q[base]), 32'd199);
      for (int i = 0; i < 200; i++) check($sformatf("stream_%0d", i), got_q[base + i], exp_q[i]);
    end

    // Backpressure: fill all credits, release one, then pop and accept together.
    m_ready = 1'b0;
    base = got_q.size();
    exp_q.delete();
    accepts = 0;
    for (int k = 0; k < 80; k++) begin
      s_valid    = 1'b1;
      s_dividend = bp_a(accepts);
      s_divisor  = 32'h40000000;
      if (s_ready) begin
        exp_q.push_back(bp_q(accepts));
        accepts++;
      end
      tick;
    end
    check("bp_accepts_full", 32'(accepts), 32'd32);
    check("bp_s_ready_low", 32'(s_ready), 32'd0);
    check("bp_head_held", m_quotient, bp_q(0));
    for (int k = 0; k < 10; k++) begin
      m_ready    = (k == 0);
      s_valid    = 1'b1;
      s_dividend = bp_a(accepts);
      if (s_ready) begin
        exp_q.push_back(bp_q(accepts));
        accepts++;
      end
      tick;
    end
    m_ready = 1'b0;
    check("bp_one_more", 32'(accepts), 32'd33);
    m_ready = 1'b1;
    stalls  = 0;
    c       = 0;
    while (accepts < 43 && c < 40) begin
      s_valid    = 1'b1;
      s_dividend = bp_a(accepts);
      if (s_ready) begin
        exp_q.push_back(bp_q(accepts));
        accepts++;
      end else begin
        stalls++;
      end
      tick;
      c++;
    end
    s_valid = 1'b0;
    check("simul_stalls", 32'(stalls), 32'd1);
    c = 0;
    while (got_q.size() < base + 43 && c < 150) begin
      tick;
      c++;
    end
    check("bp_count", 32'(got_q.size() - base), 32'd43);
    if (got_q.size() >= base + 43) begin
      for (int i = 0; i < 43; i++) check($sformatf("bp_%0d", i), got_q[base + i], exp_q[i]);
    end

    // Reset in flight: no stale results afterwards.
    for (int i = 0; i < 10; i++) push_pair(32'h40C00000, 32'h40000000, st);
    tick; tick;
    resetn = 1'b0;
    #1;
    check("midrst_s_ready", 32'(s_ready), 32'd0);
    tick; tick;
    resetn = 1'b1;
    base = got_q.size();
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick;
      if (m_valid) seen++;
    end
    check("midrst_no_valid", 32'(seen), 32'd0);
    check("midrst_no_pop", 32'(got_q.size() - base), 32'd0);
    run_one("post_rst_1_4", 32'h3F800000, 32'h40800000, 32'h3E800000);

`ifdef FLOAT_DIV_SPECIAL_EN
    run_one("sp_div_by_zero", 32'hBF800000, 32'h00000000, 32'hFF800000);
    run_one("sp_zero_div", 32'h00000000, 32'h40000000, 32'h00000000);
    run_one("sp_inf_nan", 32'h7F800000, 32'h3F800000, 32'h7FC00000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
